// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one memory access per handshake, load alignment
// and extension, register file writeback, error and timeout reporting.
module rv32i_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        err_misalign,
  output logic        err_illegal,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WB
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  rd_q, rd_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;
  logic        to_q, to_d;

  logic        accept;
  logic        is_ill;
  logic        is_mis;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    is_ill = req_we ? (req_funct3 > 3'd2)
                    : (req_funct3 == 3'd3 ||
                       req_funct3 == 3'd6 ||
                       req_funct3 == 3'd7);
    is_mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
             (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  end

  always_comb begin
    st_strb = 4'b1111;
    st_data = req_wdata;
    unique case (1'b1)
      req_funct3[1:0] == 2'b00: begin
        st_strb = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      req_funct3[1:0] == 2'b01: begin
        st_strb = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_b = mem_rdata[7:0];
    unique case (lane_q)
      2'd1:    ld_b = mem_rdata[15:8];
      2'd2:    ld_b = mem_rdata[23:16];
      2'd3:    ld_b = mem_rdata[31:24];
      default: ld_b = mem_rdata[7:0];
    endcase
    ld_h = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (f3_q)
      3'd0:    ld_data = {{24{ld_b[7]}}, ld_b};
      3'd1:    ld_data = {{16{ld_h[15]}}, ld_h};
      3'd4:    ld_data = {24'd0, ld_b};
      3'd5:    ld_data = {16'd0, ld_h};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    rd_d        = rd_q;
    rf_we_d     = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_wd_d     = rf_wd_q;
    mis_d       = 1'b0;
    ill_d       = 1'b0;
    to_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_ill) begin
            ill_d = 1'b1;
          end else if (is_mis) begin
            mis_d = 1'b1;
          end else begin
            state_d     = REQ;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wstrb_d = req_we ? st_strb : 4'b0000;
            mem_wdata_d = req_we ? st_data : 32'd0;
            f3_d        = req_funct3;
            lane_d      = req_addr[1:0];
            rd_d        = req_rd;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          cnt_d       = 8'd0;
          if (mem_we_q) begin
            state_d = IDLE;
          end else begin
            state_d = WB;
            rf_we_d = (rd_q != 5'd0);
            rf_rd_d = rd_q;
            rf_wd_d = ld_data;
          end
        end else if (cnt_q == TO_LAST) begin
          // Ack is checked first so a late ack still completes the access.
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          cnt_d       = 8'd0;
          to_d        = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'd0;
      f3_q        <= 3'd0;
      lane_q      <= 2'd0;
      rd_q        <= 5'd0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= 5'd0;
      rf_wd_q     <= 32'd0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      rd_q        <= rd_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_wd_q     <= rf_wd_d;
      mis_q       <= mis_d;
      ill_q       <= ill_d;
      to_q        <= to_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign mem_wdata    = mem_wdata_q;
  assign rf_we        = rf_we_q;
  assign rf_rd        = rf_rd_q;
  assign rf_wd        = rf_wd_q;
  assign err_misalign = mis_q;
  assign err_illegal  = ill_q;
  assign err_timeout  = to_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: vector table driven through a scoreboard queue,
// plus timeout, late-ack, reset-abort and idle-ack sequences.
module tb_rv32i_lsu;

  localparam int TO    = 8;
  localparam int K_LD  = 0;
  localparam int K_ST  = 1;
  localparam int K_MIS = 2;
  localparam int K_ILL = 3;
  localparam int K_TO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        err_misalign;
  logic        err_illegal;
  logic        err_timeout;

  always #5 clk = ~clk;

  rv32i_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wd        (rf_wd),
    .err_misalign (err_misalign),
    .err_illegal  (err_illegal),
    .err_timeout  (err_timeout)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          dly;
    int          kind;
    logic [3:0]  strb;
    logic [31:0] mwd;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] mwd;
    logic [4:0]  rd;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t ee;
  logic wb_pend = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] err_bits(input int k);
    case (k)
      K_MIS:   return 3'b001;
      K_ILL:   return 3'b010;
      K_TO:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input logic [4:0] rd,
                              input logic [31:0] rdata, input int dly,
                              input int kind, input logic [3:0] strb,
                              input logic [31:0] mwd,
                              input logic [31:0] wd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.rdata = rdata; v.dly = dly; v.kind = kind;
    v.strb = strb; v.mwd = mwd; v.wd = wd;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      wb_pend = 1'b0;
      sb.delete();
    end else begin
      if (wb_pend) begin
        wb_pend = 1'b0;
        chk("rf_we", 32'(rf_we), 32'(cur.rd != 5'd0));
        if (cur.rd != 5'd0) begin
          chk("rf_rd", 32'(rf_rd), 32'(cur.rd));
          chk("rf_wd", rf_wd, cur.wd);
        end
      end else if (rf_we) begin
        chk("rf_we_spurious", 32'(rf_we), 32'd0);
      end
      if (mem_req && mem_ack) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", 32'(mem_req), 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("mem_we", 32'(mem_we), 32'(cur.kind == K_ST));
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.strb));
          if (cur.kind == K_ST) chk("mem_wdata", mem_wdata, cur.mwd);
          else wb_pend = 1'b1;
        end
      end
      if (err_misalign || err_illegal || err_timeout) begin
        chk("err_with_rf_we", 32'(rf_we), 32'd0);
        if (sb.size() == 0) begin
          chk("err_unexpected",
              32'({err_timeout, err_illegal, err_misalign}), 32'd0);
        end else begin
          ee = sb.pop_front();
          chk("err_flags",
              32'({err_timeout, err_illegal, err_misalign}),
              32'(err_bits(ee.kind)));
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    e.kind = v.kind;
    e.addr = {v.addr[31:2], 2'b00};
    e.strb = v.strb;
    e.mwd  = v.mwd;
    e.rd   = v.rd;
    e.wd   = v.wd;
    sb.push_back(e);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_rd     = v.rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    chk("mem_req_latency", 32'(mem_req),
        32'(v.kind != K_MIS && v.kind != K_ILL));
  endtask

  task automatic ack_after(input int dly, input logic [31:0] rdata);
    repeat (dly) @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic run(input vec_t v);
    issue(v);
    if (v.kind == K_LD || v.kind == K_ST) ack_after(v.dly, v.rdata);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv [0:18];
    int   cnt;
    tv[0]  = mk(0, 3'd2, 32'h100, 0, 5'd5, 32'hDEADBEEF, 3,
                K_LD, 4'h0, 0, 32'hDEADBEEF);
    tv[1]  = mk(0, 3'd0, 32'h103, 0, 5'd1, 32'h80AA55CC, 1,
                K_LD, 4'h0, 0, 32'hFFFFFF80);
    tv[2]  = mk(0, 3'd4, 32'h103, 0, 5'd2, 32'h80AA55CC, 0,
                K_LD, 4'h0, 0, 32'h00000080);
    tv[3]  = mk(0, 3'd5, 32'h102, 0, 5'd3, 32'h80AA55CC, 2,
                K_LD, 4'h0, 0, 32'h000080AA);
    tv[4]  = mk(0, 3'd1, 32'h102, 0, 5'd4, 32'h80AA55CC, 1,
                K_LD, 4'h0, 0, 32'hFFFF80AA);
    tv[5]  = mk(0, 3'd0, 32'h100, 0, 5'd7, 32'h80AA55CC, 0,
                K_LD, 4'h0, 0, 32'hFFFFFFCC);
    tv[6]  = mk(0, 3'd1, 32'h100, 0, 5'd8, 32'h80AA55CC, 1,
                K_LD, 4'h0, 0, 32'h000055CC);
    tv[7]  = mk(0, 3'd4, 32'h101, 0, 5'd9, 32'h80AA55CC, 2,
                K_LD, 4'h0, 0, 32'h00000055);
    tv[8]  = mk(0, 3'd0, 32'h102, 0, 5'd31, 32'h80AA55CC, 0,
                K_LD, 4'h0, 0, 32'hFFFFFFAA);
    tv[9]  = mk(1, 3'd1, 32'h202, 32'h00001234, 5'd6, 0, 2,
                K_ST, 4'b1100, 32'h12341234, 0);
    tv[10] = mk(1, 3'd0, 32'h201, 32'h000000AB, 5'd6, 0, 1,
                K_ST, 4'b0010, 32'hABABABAB, 0);
    tv[11] = mk(1, 3'd2, 32'h204, 32'hCAFEF00D, 5'd6, 0, 0,
                K_ST, 4'b1111, 32'hCAFEF00D, 0);
    tv[12] = mk(1, 3'd1, 32'h200, 32'hFFFF5678, 5'd6, 0, 3,
                K_ST, 4'b0011, 32'h56785678, 0);
    tv[13] = mk(1, 3'd0, 32'h203, 32'h123456EF, 5'd6, 0, 1,
                K_ST, 4'b1000, 32'hEFEFEFEF, 0);
    tv[14] = mk(0, 3'd2, 32'h101, 0, 5'd5, 0, 0,
                K_MIS, 4'h0, 0, 0);
    tv[15] = mk(0, 3'd3, 32'h100, 0, 5'd5, 0, 0,
                K_ILL, 4'h0, 0, 0);
    tv[16] = mk(1, 3'd5, 32'h201, 32'h1, 5'd5, 0, 0,
                K_ILL, 4'h0, 0, 0);
    tv[17] = mk(1, 3'd2, 32'h20E, 32'h1, 5'd5, 0, 0,
                K_MIS, 4'h0, 0, 0);
    tv[18] = mk(0, 3'd2, 32'h10C, 0, 5'd0, 32'h55555555, 1,
                K_LD, 4'h0, 0, 32'h55555555);

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_rd     = 5'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_outs",
        32'({mem_we, mem_wstrb, rf_we, rf_rd,
             err_misalign, err_illegal, err_timeout}), 32'd0);
    chk("rst_data", mem_addr | mem_wdata | rf_wd, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) run(tv[i]);

    // Withheld ack: mem_req must stay up for exactly TO cycles.
    issue(mk(0, 3'd2, 32'h300, 0, 5'd3, 0, 0, K_TO, 4'h0, 0, 0));
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("timeout_cycles", 32'(cnt), 32'(TO));
    chk("ready_after_to", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Ack in the final counting cycle beats the timeout.
    issue(mk(1, 3'd2, 32'h304, 32'h0BADF00D, 5'd3, 0, 0,
             K_ST, 4'b1111, 32'h0BADF00D, 0));
    ack_after(TO - 1, 32'd0);
    chk("late_ack_no_to", 32'(err_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a pending load.
    issue(mk(0, 3'd2, 32'h400, 0, 5'd9, 0, 0, K_LD, 4'h0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_rf_we", 32'(rf_we), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(mk(0, 3'd2, 32'h100, 0, 5'd5, 32'h12345678, 2,
           K_LD, 4'h0, 0, 32'h12345678));

    // Ack while no request is outstanding is ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ack_rf_we", 32'(rf_we), 32'd0);
    chk("idle_ack_ready", 32'(req_ready), 32'd1);
    chk("idle_ack_mem_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
